life_ctrl: RTL and testbench
============================

Name: life_ctrl

Overview:
- Sequencer for the 8x8 Game of Life evolution datapath.
- Owns the current-generation register and drives it to the combinational next-generation rule logic, which returns evo_next.
- Commits generations on a programmable period or one at a time on a step command.
- Counts generations and halts automatically on extinction, still life, or a generation limit.

Parameters:
- GEN_W, 16, width of the generation counter.
- PERIOD, 4, clock cycles between commits in RUN (must be >= 1).
- MAX_GEN, 1000, generation limit that triggers a halt; 0 disables the limit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load  in  1  load seed into the grid (accepted in IDLE/HALT only).
- seed  in  64  initial grid; row 0 = [63:56], MSB = leftmost cell.
- start  in  1  enter continuous RUN.
- stop  in  1  leave RUN and go to IDLE (pause).
- step  in  1  commit exactly one generation.
- evo_next  in  64  next generation from the rule datapath, computed from grid.
- grid  out  64  current generation (registered), feeds the datapath.
- gen_count  out  GEN_W  generations committed since the last load.
- state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- halted  out  1  high while in HALT.
- halt_cause  out  2  00 none, 01 extinct, 10 stable, 11 generation limit.

Behaviour:
- Reset (reset==0 at a rising edge): grid=0, gen_count=0, state=IDLE, halted=0, halt_cause=00, tick counter=0. Reset overrides every other input; reset mid-RUN clears all state on the next edge.
- Commit (one edge):
  - grid<=evo_next.
  - gen_count<=gen_count+1, saturating at all-ones.
  - tick counter<=0.
  - Halt check runs on evo_next in the same edge.
- Halt check priority:
  - evo_next==0 -> 01.
  - else evo_next==grid -> 10.
  - else MAX_GEN!=0 and gen_count+1==MAX_GEN -> 11.
  - On any hit: the commit still occurs, state<=HALT, halted<=1, halt_cause latched.
- IDLE, input priority load > start > step:
  - load: grid<=seed, gen_count<=0, halt_cause<=00; stay in IDLE.
  - start: go to RUN, tick counter=0.
  - step: go to STEP.
  - stop: ignored.
- RUN:
  - Tick counter increments every cycle.
  - At PERIOD-1 -> commit.
  - stop -> IDLE and tick cleared; stop wins over a due commit (no commit that edge).
  - load, start, step: ignored.
- STEP: one cycle; commits unconditionally, then IDLE (or HALT if the check hits). Latency: step sampled at edge N, grid updated at edge N+1.
- HALT:
  - start, step, stop: ignored.
  - load: same action as in IDLE, then state<=IDLE, halted<=0.
- First commit of an all-zero seed halts with cause 01.

Optional Feature:
- Macro: LIFE_OSC2_DETECT_EN.
- Defined:
  - Adds grid_prev, loaded with grid on every commit and cleared on reset/load.
  - At a commit with gen_count>=1, evo_next==grid_prev and evo_next!=grid -> halt with cause 10 (period-2 oscillator).
  - Priority: below extinct, above limit.
- Undefined: grid_prev is absent; period-2 patterns run until MAX_GEN.

Decomposition:
- Package life_pkg:
  - GRID_W=64, ROW_W=8.
  - state_t enum (IDLE/RUN/STEP/HALT).
  - halt_cause_t enum (NONE/EXTINCT/STABLE/GENLIM).
- Sub-module life_tick: PERIOD prescaler with clear input and one-cycle "due" output, used by RUN.

Test Plan:
- Bench drives evo_next from its own combinational Life-rule model (no wrap-around edges).
- Blinker step: reset, load 64'h0000_0000_0038_0000, pulse step -> next edge grid=64'h0000_0000_1010_1000, gen_count=1, state=IDLE; second step restores the seed, gen_count=2.
- RUN cadence: PERIOD=4, blinker, start at edge 0 -> commits at edges 4, 8, 12 with gen_count 1, 2, 3; stop asserted on edge 16 (tick due) -> no commit, gen_count=3, state=IDLE.
- Still life: load 64'h0000_0018_1800_0000, start -> first commit gives halted=1, halt_cause=10, gen_count=1, grid unchanged; start/step then ignored.
- Extinction: load 64'h0000_0010_0000_0000, step -> grid=0, halt_cause=01, state=HALT; load new seed -> IDLE, halted=0, gen_count=0.
- Limit vs oscillator: MAX_GEN=5, blinker, start:
  - macro undefined -> HALT at gen_count=5 with cause 11.
  - LIFE_OSC2_DETECT_EN defined -> HALT at gen_count=2 with cause 10.
- Reset/priority: reset low mid-RUN -> all outputs zero next edge; load+start in the same IDLE cycle -> seed loaded, state stays IDLE.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and widths for the 8x8 Game of Life sequencer.
package life_pkg;

  localparam int unsigned GRID_W = 64;
  localparam int unsigned ROW_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    EXTINCT = 2'b01,
    STABLE  = 2'b10,
    GENLIM  = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/life_tick.sv
// Commit-period prescaler: counts 0..PERIOD-1 while not cleared, flags the last count.
module life_tick #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic due_c
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt;

  assign due_c = !clr && (cnt == CNT_W'(PERIOD - 1));

  // Wraps to zero on the due cycle so the next period starts cleanly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || due_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_ctrl.sv
// Game of Life generation sequencer: owns the grid, commits evo_next, counts and auto-halts.
// Optional macro LIFE_OSC2_DETECT_EN adds period-2 oscillator detection.
module life_ctrl
  import life_pkg::*;
#(
  parameter int unsigned GEN_W   = 16,
  parameter int unsigned PERIOD  = 4,
  parameter int unsigned MAX_GEN = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [GRID_W-1:0] seed,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [GRID_W-1:0] evo_next,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output state_t            state,
  output logic              halted,
  output halt_cause_t       halt_cause
);

  logic        tick_clr_c;
  logic        tick_due_c;
  logic        load_c;
  logic        commit_c;
  logic        limit_c;
  halt_cause_t cause_c;

  assign tick_clr_c = (state != RUN) || stop;

  life_tick #(.PERIOD(PERIOD)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr_c),
    .due_c (tick_due_c)
  );

  assign load_c   = load && ((state == IDLE) || (state == HALT));
  assign commit_c = (state == STEP) || ((state == RUN) && !stop && tick_due_c);
  assign limit_c  = (MAX_GEN != 0) && ((32'(gen_count) + 32'd1) == 32'(MAX_GEN));

`ifdef LIFE_OSC2_DETECT_EN
  logic [GRID_W-1:0] grid_prev;
  logic              osc_c;

  assign osc_c = (gen_count != '0) && (evo_next == grid_prev) && (evo_next != grid);

  // Generation before the current one, for period-2 comparison.
  always_ff @(posedge clk) begin
    if (!reset || load_c) begin
      grid_prev <= '0;
    end else if (commit_c) begin
      grid_prev <= grid;
    end
  end
`endif

  // Halt check on the incoming generation, highest priority first.
  always_comb begin
    cause_c = NONE;
    if (evo_next == '0) begin
      cause_c = EXTINCT;
    end else if (evo_next == grid) begin
      cause_c = STABLE;
`ifdef LIFE_OSC2_DETECT_EN
    end else if (osc_c) begin
      cause_c = STABLE;
`endif
    end else if (limit_c) begin
      cause_c = GENLIM;
    end
  end

  // Control FSM and grid/counter state; load and commit are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grid       <= '0;
      gen_count  <= '0;
      state      <= IDLE;
      halted     <= 1'b0;
      halt_cause <= NONE;
    end else if (load_c) begin
      grid       <= seed;
      gen_count  <= '0;
      state      <= IDLE;
      halted     <= 1'b0;
      halt_cause <= NONE;
    end else if (commit_c) begin
      grid      <= evo_next;
      gen_count <= (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);
      if (cause_c != NONE) begin
        state      <= HALT;
        halted     <= 1'b1;
        halt_cause <= cause_c;
      end else if (state == STEP) begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
          end else if (step) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl; evo_next comes from a bounded-edge Life rule model.
module tb_life_ctrl;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_0038_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0000_1010_1000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] seed;
  logic        start;
  logic        stop;
  logic        step;
  logic [63:0] evo_next;
  logic [63:0] grid;
  logic [15:0] gen_count;
  logic [1:0]  state;
  logic        halted;
  logic [1:0]  halt_cause;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  life_ctrl #(.GEN_W(16), .PERIOD(4), .MAX_GEN(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .seed       (seed),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .evo_next   (evo_next),
    .grid       (grid),
    .gen_count  (gen_count),
    .state      (state),
    .halted     (halted),
    .halt_cause (halt_cause)
  );

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int          cnt;
    logic        alive;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8) begin
              if (g[63 - ((r + dr) * 8 + (c + dc))]) cnt++;
            end
          end
        end
        alive = g[63 - (r * 8 + c)];
        n[63 - (r * 8 + c)] = alive ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    end
    return n;
  endfunction

  always_comb evo_next = life_next(grid);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [63:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    seed  = '0;
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    tick(2);
    reset = 1'b1;
    check("rst_grid", grid, 64'h0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cause", 64'(halt_cause), 64'd0);

    // Blinker single-stepping
    do_load(BLINK_H);
    check("bl_load", grid, BLINK_H);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("bl_stepstate", 64'(state), 64'd2);
    check("bl_nocommit", grid, BLINK_H);
    tick();
    check("bl_step1_grid", grid, BLINK_V);
    check("bl_step1_gen", 64'(gen_count), 64'd1);
    check("bl_step1_state", 64'(state), 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("bl_step2_grid", grid, BLINK_H);
    check("bl_step2_gen", 64'(gen_count), 64'd2);

    // RUN cadence, commits every 4 edges, stop on a due tick suppresses the commit
    do_load(BLINK_H);
    check("run_gen0", 64'(gen_count), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_state", 64'(state), 64'd1);
    for (int e = 1; e < 16; e++) begin
      tick();
      check($sformatf("run_gen_e%0d", e), 64'(gen_count), 64'(e / 4));
      check($sformatf("run_grid_e%0d", e), grid, ((e / 4) % 2 == 1) ? BLINK_V : BLINK_H);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_gen", 64'(gen_count), 64'd3);
    check("stop_state", 64'(state), 64'd0);
    check("stop_grid", grid, BLINK_V);
    tick(5);
    check("idle_hold_gen", 64'(gen_count), 64'd3);

    // Still life halts on the first commit
    do_load(BLOCK);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("still_pre", 64'(halted), 64'd0);
    tick();
    check("still_halted", 64'(halted), 64'd1);
    check("still_cause", 64'(halt_cause), 64'd2);
    check("still_gen", 64'(gen_count), 64'd1);
    check("still_grid", grid, BLOCK);
    check("still_state", 64'(state), 64'd3);
    start = 1'b1;
    step  = 1'b1;
    stop  = 1'b1;
    tick(3);
    start = 1'b0;
    step  = 1'b0;
    stop  = 1'b0;
    check("halt_ign_state", 64'(state), 64'd3);
    check("halt_ign_gen", 64'(gen_count), 64'd1);

    // Extinction from a lone cell, then load out of HALT
    do_load(SINGLE);
    check("hload_state", 64'(state), 64'd0);
    check("hload_halted", 64'(halted), 64'd0);
    check("hload_cause", 64'(halt_cause), 64'd0);
    check("hload_gen", 64'(gen_count), 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("ext_grid", grid, 64'h0);
    check("ext_cause", 64'(halt_cause), 64'd1);
    check("ext_state", 64'(state), 64'd3);
    check("ext_gen", 64'(gen_count), 64'd1);
    do_load(BLINK_H);
    check("ext_reload_state", 64'(state), 64'd0);
    check("ext_reload_halted", 64'(halted), 64'd0);
    check("ext_reload_gen", 64'(gen_count), 64'd0);

    // Generation limit versus period-2 detection
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !halted; i++) tick();
    check("lim_halted", 64'(halted), 64'd1);
`ifdef LIFE_OSC2_DETECT_EN
    check("osc_gen", 64'(gen_count), 64'd2);
    check("osc_cause", 64'(halt_cause), 64'd2);
    check("osc_grid", grid, BLINK_H);
`else
    check("lim_gen", 64'(gen_count), 64'd5);
    check("lim_cause", 64'(halt_cause), 64'd3);
    check("lim_grid", grid, BLINK_V);
`endif

    // Reset mid-RUN, then load wins over start
    do_load(BLINK_H);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(6);
    check("mid_gen", 64'(gen_count), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_grid", grid, 64'h0);
    check("mrst_gen", 64'(gen_count), 64'd0);
    check("mrst_state", 64'(state), 64'd0);
    check("mrst_halted", 64'(halted), 64'd0);
    check("mrst_cause", 64'(halt_cause), 64'd0);
    load  = 1'b1;
    start = 1'b1;
    seed  = BLOCK;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("prio_grid", grid, BLOCK);
    check("prio_state", 64'(state), 64'd0);
    tick(6);
    check("prio_hold", 64'(state), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
